// File: rtl/flu_wb_arbiter.sv
// Writeback arbiter for the FLU port: combinational producers always win, and each
// sequential unit gets a one-entry holding slot with round-robin draining.

module flu_wb_hold_slot #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     capture_i,
    input  logic                     release_i,
    input  logic [XLEN-1:0]          result_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     held_o,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            held_o     <= 1'b0;
            result_o   <= '0;
            trans_id_o <= '0;
        end else if (flush_i) begin
            held_o <= 1'b0;
        end else if (capture_i) begin
            held_o     <= 1'b1;
            result_o   <= result_i;
            trans_id_o <= trans_id_i;
        end else if (release_i) begin
            held_o <= 1'b0;
        end
    end
endmodule

module flu_wb_arbiter #(
    parameter int unsigned NR_SEQ        = 2,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            comb_valid_i,
    input  logic [XLEN-1:0]                 comb_result_i,
    input  logic [TRANS_ID_BITS-1:0]        comb_trans_id_i,
    input  logic [NR_SEQ-1:0]               seq_valid_i,
    input  logic [NR_SEQ*XLEN-1:0]          seq_result_i,
    input  logic [NR_SEQ*TRANS_ID_BITS-1:0] seq_trans_id_i,
    output logic [NR_SEQ-1:0]               seq_ready_o,
    output logic                            wb_valid_o,
    output logic [XLEN-1:0]                 wb_result_o,
    output logic [TRANS_ID_BITS-1:0]        wb_trans_id_o,
    output logic [NR_SEQ:0]                 wb_src_o,
    output logic                            comb_stall_o
);
    localparam int unsigned RR_W = (NR_SEQ > 1) ? $clog2(NR_SEQ) : 1;

    logic [NR_SEQ-1:0]                         held, req, capture, release_v;
    logic [NR_SEQ-1:0][XLEN-1:0]               hold_result;
    logic [NR_SEQ-1:0][TRANS_ID_BITS-1:0]      hold_id;
    logic [RR_W-1:0]                           rr_q, gnt_idx;
    logic                                      gnt_found, seq_gnt;
    logic [3:0]                                starve_q;
    int                                        rr_idx;

    // A unit with a held entry is not ready, so a live valid only counts when empty.
    assign req         = held | seq_valid_i;
    assign seq_ready_o = ~held;
    assign seq_gnt     = gnt_found & ~comb_valid_i & ~flush_i;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_idx    = 0;
        for (int k = 0; k < int'(NR_SEQ); k++) begin
            rr_idx = int'(rr_q) + k;
            if (rr_idx >= int'(NR_SEQ)) rr_idx = rr_idx - int'(NR_SEQ);
            if (!gnt_found && req[rr_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = RR_W'(rr_idx);
            end
        end
    end

    for (genvar i = 0; i < int'(NR_SEQ); i++) begin : g_slot
        assign release_v[i] = seq_gnt & (int'(gnt_idx) == i);
        assign capture[i]   = seq_valid_i[i] & ~held[i] & ~flush_i & ~release_v[i];

        flu_wb_hold_slot #(.XLEN(XLEN), .TRANS_ID_BITS(TRANS_ID_BITS)) u_slot (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .flush_i   (flush_i),
            .capture_i (capture[i]),
            .release_i (release_v[i]),
            .result_i  (seq_result_i[i*XLEN +: XLEN]),
            .trans_id_i(seq_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS]),
            .held_o    (held[i]),
            .result_o  (hold_result[i]),
            .trans_id_o(hold_id[i])
        );
    end

    always_comb begin
        wb_valid_o    = (comb_valid_i | (|req)) & ~flush_i;
        wb_result_o   = '0;
        wb_trans_id_o = '0;
        wb_src_o      = '0;
        if (wb_valid_o) begin
            if (comb_valid_i) begin
                wb_result_o   = comb_result_i;
                wb_trans_id_o = comb_trans_id_i;
                wb_src_o[0]   = 1'b1;
            end else if (held[gnt_idx]) begin
                wb_result_o   = hold_result[gnt_idx];
                wb_trans_id_o = hold_id[gnt_idx];
                wb_src_o[int'(gnt_idx)+1] = 1'b1;
            end else begin
                wb_result_o   = seq_result_i[int'(gnt_idx)*XLEN +: XLEN];
                wb_trans_id_o = seq_trans_id_i[int'(gnt_idx)*TRANS_ID_BITS +: TRANS_ID_BITS];
                wb_src_o[int'(gnt_idx)+1] = 1'b1;
            end
        end
    end

    // Starvation: count cycles a held entry loses to comb; issue is asked to bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            starve_q <= '0;
        end else begin
            if (seq_gnt)
                rr_q <= (int'(gnt_idx) == int'(NR_SEQ) - 1) ? '0 : gnt_idx + RR_W'(1);
            if (flush_i || seq_gnt)
                starve_q <= '0;
            else if ((|held) && comb_valid_i && starve_q != 4'hF)
                starve_q <= starve_q + 4'd1;
        end
    end

    assign comb_stall_o = (starve_q >= 4'(STARVE_LIMIT));

endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Directed bench for flu_wb_arbiter: inputs driven 1ns after posedge, outputs sampled on negedge.

module tb_flu_wb_arbiter;
    localparam int NR_SEQ = 2;
    localparam int XLEN   = 64;
    localparam int TID    = 3;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic                     flush_i;
    logic                     comb_valid_i;
    logic [XLEN-1:0]          comb_result_i;
    logic [TID-1:0]           comb_trans_id_i;
    logic [NR_SEQ-1:0]        seq_valid_i;
    logic [NR_SEQ*XLEN-1:0]   seq_result_i;
    logic [NR_SEQ*TID-1:0]    seq_trans_id_i;
    logic [NR_SEQ-1:0]        seq_ready_o;
    logic                     wb_valid_o;
    logic [XLEN-1:0]          wb_result_o;
    logic [TID-1:0]           wb_trans_id_o;
    logic [NR_SEQ:0]          wb_src_o;
    logic                     comb_stall_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n_mult = 0;
    int n_cord = 0;

    flu_wb_arbiter #(.NR_SEQ(NR_SEQ), .XLEN(XLEN), .TRANS_ID_BITS(TID), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .comb_valid_i(comb_valid_i), .comb_result_i(comb_result_i), .comb_trans_id_i(comb_trans_id_i),
        .seq_valid_i(seq_valid_i), .seq_result_i(seq_result_i), .seq_trans_id_i(seq_trans_id_i),
        .seq_ready_o(seq_ready_o), .wb_valid_o(wb_valid_o), .wb_result_o(wb_result_o),
        .wb_trans_id_o(wb_trans_id_o), .wb_src_o(wb_src_o), .comb_stall_o(comb_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_seq(input int i, input logic v, input logic [XLEN-1:0] r, input logic [TID-1:0] id);
        seq_valid_i[i]               = v;
        seq_result_i[i*XLEN +: XLEN] = r;
        seq_trans_id_i[i*TID +: TID] = id;
    endtask

    task automatic set_comb(input logic v, input logic [XLEN-1:0] r, input logic [TID-1:0] id);
        comb_valid_i    = v;
        comb_result_i   = r;
        comb_trans_id_i = id;
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic [63:0] r,
                          input logic [TID-1:0] id, input logic [NR_SEQ:0] src);
        chk({tag, "_valid"}, 64'(wb_valid_o), 64'(v));
        chk({tag, "_result"}, wb_result_o, r);
        chk({tag, "_id"}, 64'(wb_trans_id_o), 64'(id));
        chk({tag, "_src"}, 64'(wb_src_o), 64'(src));
    endtask

    // Issue must never present a comb result while a bubble is requested.
    always @(negedge clk_i)
        if (rst_ni === 1'b1) chk("comb_under_stall", 64'(comb_valid_i & comb_stall_o), 64'd0);

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0;
        set_comb(1'b0, '0, '0);
        seq_valid_i = '0; seq_result_i = '0; seq_trans_id_i = '0;
        #2;
        chk("rst_ready", 64'(seq_ready_o), 64'b11);
        chk("rst_stall", 64'(comb_stall_o), 64'd0);
        chk_wb("rst", 1'b0, 64'd0, 3'd0, 3'b000);
        #10 rst_ni = 1'b1;
        tick();

        // 1: comb writeback, zero latency
        set_comb(1'b1, 64'h55, 3'd2);
        @(negedge clk_i);
        chk_wb("t1", 1'b1, 64'h55, 3'd2, 3'b001);
        chk("t1_ready", 64'(seq_ready_o), 64'b11);
        tick(); set_comb(1'b0, '0, '0);

        // 2: both units at once, rr=0
        set_seq(0, 1'b1, 64'hA, 3'd1); set_seq(1, 1'b1, 64'hB, 3'd3);
        @(negedge clk_i);
        chk_wb("t2c0", 1'b1, 64'hA, 3'd1, 3'b010);
        tick(); seq_valid_i = '0;
        @(negedge clk_i);
        chk("t2c1_ready", 64'(seq_ready_o), 64'b01);
        chk_wb("t2c1", 1'b1, 64'hB, 3'd3, 3'b100);
        tick();
        @(negedge clk_i);
        chk("t2c2_ready", 64'(seq_ready_o), 64'b11);
        chk("t2c2_valid", 64'(wb_valid_o), 64'd0);
        tick();

        // 3: starvation of a held cordic result
        set_comb(1'b1, 64'h77, 3'd5); set_seq(1, 1'b1, 64'hC, 3'd4);
        @(negedge clk_i);
        chk_wb("t3cap", 1'b1, 64'h77, 3'd5, 3'b001);
        tick(); seq_valid_i = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("t3_stall_lo", 64'(comb_stall_o), 64'd0);
            chk("t3_ready", 64'(seq_ready_o), 64'b01);
            tick();
        end
        set_comb(1'b0, '0, '0);
        @(negedge clk_i);
        chk("t3_stall_hi", 64'(comb_stall_o), 64'd1);
        chk_wb("t3drain", 1'b1, 64'hC, 3'd4, 3'b100);
        tick();
        @(negedge clk_i);
        chk("t3_stall_fall", 64'(comb_stall_o), 64'd0);
        chk("t3_ready_after", 64'(seq_ready_o), 64'b11);
        tick();

        // 4: a live mult grant moves rr to 1, then repeated bursts drain cordic first
        set_seq(0, 1'b1, 64'h10, 3'd0);
        @(negedge clk_i);
        chk_wb("t4live", 1'b1, 64'h10, 3'd0, 3'b010);
        tick(); seq_valid_i = '0;
        for (int b = 0; b < 4; b++) begin
            set_comb(1'b1, 64'h20 + 64'(b), 3'd6);
            set_seq(0, 1'b1, 64'h30 + 64'(b), 3'd1);
            set_seq(1, 1'b1, 64'h40 + 64'(b), 3'd2);
            @(negedge clk_i);
            chk("t4_comb_src", 64'(wb_src_o), 64'b001);
            tick(); set_comb(1'b0, '0, '0); seq_valid_i = '0;
            @(negedge clk_i);
            chk_wb("t4first", 1'b1, 64'h40 + 64'(b), 3'd2, 3'b100);
            if (wb_src_o == 3'b100) n_cord++;
            tick();
            @(negedge clk_i);
            chk_wb("t4second", 1'b1, 64'h30 + 64'(b), 3'd1, 3'b010);
            if (wb_src_o == 3'b010) n_mult++;
            tick();
        end
        chk("t4_cordic_grants", 64'(n_cord), 64'd4);
        chk("t4_mult_grants", 64'(n_mult), 64'd4);

        // 5: flush discards a held mult entry
        set_comb(1'b1, 64'h99, 3'd7); set_seq(0, 1'b1, 64'hA, 3'd1);
        tick(); set_comb(1'b0, '0, '0); seq_valid_i = '0; flush_i = 1'b1;
        @(negedge clk_i);
        chk("t5_flush_valid", 64'(wb_valid_o), 64'd0);
        chk("t5_flush_ready", 64'(seq_ready_o), 64'b10);
        tick(); flush_i = 1'b0;
        @(negedge clk_i);
        chk("t5_ready", 64'(seq_ready_o), 64'b11);
        chk("t5_no_wb", 64'(wb_valid_o), 64'd0);
        tick();
        @(negedge clk_i);
        chk("t5_no_wb2", 64'(wb_valid_o), 64'd0);
        tick();

        // 6: async reset while two entries are held
        set_comb(1'b1, 64'h11, 3'd1);
        set_seq(0, 1'b1, 64'hD, 3'd2); set_seq(1, 1'b1, 64'hE, 3'd3);
        tick(); set_comb(1'b0, '0, '0); seq_valid_i = '0;
        @(negedge clk_i);
        chk("t6_ready_held", 64'(seq_ready_o), 64'b00);
        chk_wb("t6drain", 1'b1, 64'hE, 3'd3, 3'b100);
        #1 rst_ni = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(seq_ready_o), 64'b11);
        chk("t6_rst_stall", 64'(comb_stall_o), 64'd0);
        chk_wb("t6rst", 1'b0, 64'd0, 3'd0, 3'b000);
        #1 rst_ni = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("t6_post_valid", 64'(wb_valid_o), 64'd0);
            chk("t6_post_ready", 64'(seq_ready_o), 64'b11);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
